psp_mem_arbiter: RTL
====================

Name: psp_mem_arbiter

Overview:
- Shares one downstream memory port between the PSP instruction-fetch requester (I) and load/store requester (D); both use the team's memory_if handshake.
- Sits between the core and the unified memory model/BRAM. Round-robin on ties, one outstanding transaction at a time, plus a watchdog that flags a hung memory.
- Exposes grant/owner status so the bench and the RVFI monitor can correlate memory traffic with retired instructions.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; the mask width is DATA_W/8.
- TIMEOUT, 1024, maximum cycles a granted transaction may wait for mem_resp before err_timeout is raised. Must be ≥2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- i_read  in  1  instruction read request; held until i_resp.
- i_addr  in  ADDR_W  instruction address.
- i_rdata  out  DATA_W  instruction read data; valid when i_resp=1.
- i_resp  out  1  one-cycle completion pulse to I.
- d_read / d_write  in  1 each  data request; held until d_resp. Both high at once is illegal.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_wmask  in  DATA_W/8  byte enables.
- d_rdata  out  DATA_W  load data.
- d_resp  out  1  one-cycle completion pulse to D.
- mem_read / mem_write  out  1 each  downstream command; held until mem_resp.
- mem_addr  out  ADDR_W  downstream address.
- mem_wdata  out  DATA_W  downstream store data.
- mem_wmask  out  DATA_W/8  downstream byte enables.
- mem_rdata  in  DATA_W  downstream read data.
- mem_resp  in  1  downstream completion.
- owner  out  2  00 idle, 01 I, 10 D.
- err_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, last_grant=D, so I wins the first tie.
  - All mem_* outputs, i_resp, d_resp, owner and err_timeout are 0. i_rdata and d_rdata are 0.
- FSM states: IDLE, GNT_I, GNT_D.
- IDLE:
  - Only i_read pending → GNT_I.
  - Only d_read or d_write pending → GNT_D.
  - Both pending → grant the requester that is not last_grant.
  - On grant, the command is captured into registers and mem_* is driven from the next cycle (1-cycle grant latency).
  - last_grant updates at grant.
- GNT_x:
  - mem_* is held constant from the captured registers; requester input changes are ignored.
  - When mem_resp=1, mem_rdata is registered to x_rdata and x_resp pulses for exactly 1 cycle, the cycle after mem_resp.
  - mem_read and mem_write deassert in the cycle after mem_resp. The FSM returns to IDLE.
- Back-to-back:
  - IDLE re-arbitrates no earlier than the cycle in which x_resp is high.
  - The completing requester must drop its request in that cycle, per memory_if. A request still high in that cycle is treated as a new request.
  - Minimum occupancy: 2 cycles of arbiter overhead plus the memory latency.
- Data outputs:
  - x_rdata holds its last value between responses.
  - d_rdata updates only on a completed D read; D writes leave d_rdata unchanged.
- Ties under load: with both requesters continuously pending, grants alternate I, D, I, D…, so neither requester is starved.
- Watchdog:
  - A counter clears at grant and increments each GNT_x cycle without mem_resp.
  - When it reaches TIMEOUT, err_timeout sets and stays set until reset.
  - The FSM keeps waiting; no abort.
- Simultaneous events: mem_resp in the same cycle as a new request is not a conflict. The new request waits for IDLE.
- Reset mid-transaction: the FSM returns to IDLE, mem_* drop immediately (asynchronously) and no resp is generated.
- Illegal input: d_read and d_write both high is not supported. The implementation gives read priority and the bench asserts the condition never occurs.
- Width rules: no address translation. Addresses and masks pass through bit-exact.

Decomposition:
- Shared package psp_mem_pkg holds:
  - arb_state_t enum (IDLE, GNT_I, GNT_D);
  - owner encoding constants OWNER_IDLE, OWNER_I, OWNER_D;
  - a mem_req_t struct (read, write, addr, wdata, wmask) used for the captured command.
- One natural sub-module: psp_rr_arb2, a 2-way round-robin picker holding last_grant.

Test Plan:
- Reset: hold reset=0 with i_read=1 → mem_read=0, owner=00, err_timeout=0. Release reset → mem_read=1 and mem_addr=i_addr one cycle later, owner=01.
- Single D write: addr 0x100, wdata 0xDEADBEEF, wmask 0xF, memory latency 3 → mem_* matches the request bit-exact, d_resp pulses once, and d_rdata is unchanged.
- Tie: i_read and d_read asserted together, continuously re-requesting for 4 transactions → grant order I, D, I, D; each i_rdata/d_rdata equals the model data for its address.
- Back-to-back: D read completes while I is pending → I is granted in the cycle of d_resp; mem_addr switches with no overlapping command.
- Timeout: TIMEOUT=16 and memory never responds → err_timeout rises at exactly the 16th cycle after grant and stays high. A later mem_resp still completes the transaction.
- Mid-transaction reset: reset=0 during GNT_D → mem_write drops in the same cycle, no d_resp, and state is IDLE after release.

Source files
------------

// File: rtl/psp_mem_pkg.sv
// Shared types for the PSP memory arbiter: FSM states, owner codes and the captured command.
package psp_mem_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned MEM_MASK_W = MEM_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  localparam logic [1:0] OWNER_IDLE = 2'b00;
  localparam logic [1:0] OWNER_I    = 2'b01;
  localparam logic [1:0] OWNER_D    = 2'b10;

  typedef struct packed {
    logic                  read;
    logic                  write;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic [MEM_MASK_W-1:0] wmask;
  } mem_req_t;

  function automatic logic [1:0] owner_of(input arb_state_t s);
    case (s)
      GNT_I:   return OWNER_I;
      GNT_D:   return OWNER_D;
      default: return OWNER_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/psp_rr_arb2.sv
// Two-way round-robin picker; requester A wins ties when B was granted last.
module psp_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_c_o,
  output logic gnt_b_c_o
);

  logic last_b_q, last_b_d;

  always_comb begin
    gnt_a_c_o = req_a_i & (~req_b_i | last_b_q);
    gnt_b_c_o = req_b_i & ~gnt_a_c_o;
    last_b_d  = last_b_q;
    if (en_i && gnt_a_c_o) begin
      last_b_d = 1'b0;
    end else if (en_i && gnt_b_c_o) begin
      last_b_d = 1'b1;
    end
  end

  // Reset to "B granted last" so A wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end

endmodule

// File: rtl/psp_mem_arbiter.sv
// Shares one downstream memory port between the PSP fetch (I) and load/store (D) requesters,
// one transaction at a time, with a sticky watchdog for a memory that never responds.
module psp_mem_arbiter
  import psp_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_read,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_resp,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_resp,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp,
  output logic [1:0]          owner,
  output logic                err_timeout
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

  arb_state_t        state_q, state_d;
  mem_req_t          req_q, req_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_resp_q, i_resp_d;
  logic              d_resp_q, d_resp_d;
  logic              err_q, err_d;
  logic [1:0]        owner_q, owner_d;
  logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;

  logic arb_en_c, d_req_c, gnt_i_c, gnt_d_c;

  assign d_req_c  = d_read | d_write;
  assign arb_en_c = (state_q == IDLE);

  psp_rr_arb2 u_rr (
    .clk       (clk),
    .rst_n     (reset),
    .en_i      (arb_en_c),
    .req_a_i   (i_read),
    .req_b_i   (d_req_c),
    .gnt_a_c_o (gnt_i_c),
    .gnt_b_c_o (gnt_d_c)
  );

  // Next state: capture at grant, hold while granted, complete on mem_resp.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_resp_d  = 1'b0;
    d_resp_d  = 1'b0;
    err_d     = err_q;
    wd_cnt_d  = wd_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (gnt_i_c) begin
          state_d     = GNT_I;
          req_d.read  = 1'b1;
          req_d.write = 1'b0;
          req_d.addr  = MEM_ADDR_W'(i_addr);
          req_d.wdata = '0;
          req_d.wmask = '0;
          wd_cnt_d    = '0;
        end else if (gnt_d_c) begin
          // A simultaneous read and write is illegal; the read wins.
          state_d     = GNT_D;
          req_d.read  = d_read;
          req_d.write = d_write & ~d_read;
          req_d.addr  = MEM_ADDR_W'(d_addr);
          req_d.wdata = MEM_DATA_W'(d_wdata);
          req_d.wmask = MEM_MASK_W'(d_wmask);
          wd_cnt_d    = '0;
        end
      end
      GNT_I, GNT_D: begin
        if (mem_resp) begin
          if (state_q == GNT_I) begin
            i_rdata_d = mem_rdata;
            i_resp_d  = 1'b1;
          end else begin
            if (req_q.read) begin
              d_rdata_d = mem_rdata;
            end
            d_resp_d = 1'b1;
          end
          req_d.read  = 1'b0;
          req_d.write = 1'b0;
          state_d     = IDLE;
        end else if (wd_cnt_q != CNT_W'(TIMEOUT)) begin
          wd_cnt_d = wd_cnt_q + CNT_W'(1);
          if (wd_cnt_d == CNT_W'(TIMEOUT)) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    owner_d = owner_of(state_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      req_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_resp_q  <= 1'b0;
      d_resp_q  <= 1'b0;
      err_q     <= 1'b0;
      owner_q   <= OWNER_IDLE;
      wd_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_resp_q  <= i_resp_d;
      d_resp_q  <= d_resp_d;
      err_q     <= err_d;
      owner_q   <= owner_d;
      wd_cnt_q  <= wd_cnt_d;
    end
  end

  assign mem_read    = req_q.read;
  assign mem_write   = req_q.write;
  assign mem_addr    = ADDR_W'(req_q.addr);
  assign mem_wdata   = DATA_W'(req_q.wdata);
  assign mem_wmask   = MASK_W'(req_q.wmask);
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign i_resp      = i_resp_q;
  assign d_resp      = d_resp_q;
  assign owner       = owner_q;
  assign err_timeout = err_q;

endmodule
